// File: rtl/truth_table_sweep_ctrl_pkg.sv
// Shared types, default sizing and a popcount helper for the truth-table sweep sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
package truth_table_sweep_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam int              DEF_N_IN    = 4;
   localparam logic [15:0]     DEF_EXP_TT  = 16'h4BF8;
   localparam int              DEF_SETTLE  = 4;
   localparam int              DEF_SAMPLES = 2;
   localparam int              N_VEC       = 2**DEF_N_IN;
   localparam int              CNT_W       = $clog2(((DEF_SETTLE > DEF_SAMPLES) ? DEF_SETTLE : DEF_SAMPLES) + 1);

   // Generic up to 64 bits; callers zero-extend narrower vectors.
   function automatic int unsigned popcount(input logic [63:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 64; i++) n += int'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/truth_table_sweep_ctrl_if.sv
// Host control/result bus plus the vector/response pair toward the circuit under test.
// Latency: n/a. Backpressure: none; start/abort are single-cycle level samples.
interface truth_table_sweep_ctrl_if #(parameter int N_IN = 4);
   localparam int NV = 2**N_IN;
   localparam int CW = $clog2(NV + 1);

   logic            start;
   logic            abort;
   logic [N_IN-1:0] dut_in;
   logic            dut_out;
   logic            busy;
   logic            done;
   logic            pass;
   logic [NV-1:0]   result_tt;
   logic [NV-1:0]   mismatch_mask;
   logic [NV-1:0]   unstable_mask;
   logic [CW-1:0]   mismatch_count;

   modport master (
      input  start, abort, dut_out,
      output dut_in, busy, done, pass, result_tt, mismatch_mask, unstable_mask, mismatch_count
   );

   modport slave (
      output start, abort, dut_out,
      input  dut_in, busy, done, pass, result_tt, mismatch_mask, unstable_mask, mismatch_count
   );
endinterface

// File: rtl/truth_table_sweep_ctrl_popcount.sv
// Combinational popcount over a W-bit vector (W <= 64).
// Latency: 0 cycles. Backpressure: none.
module tt_popcount
   import truth_table_sweep_ctrl_pkg::*;
#(
   parameter int W  = 16,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  i_vec,
   output logic [CW-1:0] o_cnt
);
   assign o_cnt = CW'(popcount(64'(i_vec)));
endmodule

// File: rtl/truth_table_sweep_ctrl.sv
// Sweeps all input vectors of a combinational circuit, samples its output and grades the truth table.
// Latency: done 2**N_IN*(SETTLE_CYCLES+SAMPLES) cycles after start. Backpressure: start ignored while busy; abort always wins.
module truth_table_sweep_ctrl
   import truth_table_sweep_ctrl_pkg::*;
#(
   parameter int               N_IN          = DEF_N_IN,
   parameter logic [2**N_IN-1:0] EXP_TT      = DEF_EXP_TT,
   parameter int               SETTLE_CYCLES = DEF_SETTLE,
   parameter int               SAMPLES       = DEF_SAMPLES
) (
   input  logic clk,
   input  logic rst_n,
   truth_table_sweep_ctrl_if.master bus
);
   localparam int NV      = 2**N_IN;
   localparam int PCW     = $clog2(NV + 1);
   localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
   localparam int CTW     = $clog2(CNT_MAX + 1);
   localparam logic [N_IN-1:0] IDX_LAST   = N_IN'(NV - 1);
   localparam logic [CTW-1:0]  SETTLE_LD  = CTW'(SETTLE_CYCLES - 1);
   localparam logic [CTW-1:0]  SAMPLE_LD  = CTW'(SAMPLES - 1);

   state_t          r_state, w_state_nxt;
   logic [CTW-1:0]  r_cnt, w_cnt_nxt;
   logic [N_IN-1:0] r_idx, w_idx_nxt;
   logic            r_ref;
   logic [NV-1:0]   r_result, r_unstable, r_mismatch;
   logic [PCW-1:0]  r_count;
   logic            r_pass, r_done;

   logic            w_clear, w_sample, w_first, w_finish;
   logic [NV-1:0]   w_result_nxt, w_unstable_nxt, w_mismatch_nxt;
   logic [PCW-1:0]  w_pop;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_clear     = 1'b0;
      w_sample    = 1'b0;
      w_first     = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_state_nxt = SETTLE;
               w_cnt_nxt   = SETTLE_LD;
               w_idx_nxt   = '0;
               w_clear     = 1'b1;
            end
         end
         SETTLE: begin
            if (r_cnt == '0) begin
               w_state_nxt = SAMPLE;
               w_cnt_nxt   = SAMPLE_LD;
            end else begin
               w_cnt_nxt   = r_cnt - 1'b1;
            end
         end
         SAMPLE: begin
            w_sample = 1'b1;
            w_first  = (r_cnt == SAMPLE_LD);
            if (r_cnt == '0) begin
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = DONE;
                  w_finish    = 1'b1;
               end else begin
                  w_state_nxt = SETTLE;
                  w_cnt_nxt   = SETTLE_LD;
                  w_idx_nxt   = r_idx + 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // Abort overrides everything, including a start in the same cycle.
      if (bus.abort) begin
         w_state_nxt = IDLE;
         w_idx_nxt   = '0;
         w_clear     = 1'b0;
         w_sample    = 1'b0;
         w_first     = 1'b0;
         w_finish    = 1'b0;
      end
   end

   // Next-value views so the grade on DONE entry includes a same-cycle final sample.
   always_comb begin
      w_result_nxt   = r_result;
      w_unstable_nxt = r_unstable;
      if (w_sample && w_first)
         w_result_nxt[r_idx] = bus.dut_out;
      if (w_sample && !w_first && (bus.dut_out != r_ref))
         w_unstable_nxt[r_idx] = 1'b1;
   end

   assign w_mismatch_nxt = w_result_nxt ^ EXP_TT;

   tt_popcount #(.W(NV), .CW(PCW)) u_pop (
      .i_vec (w_mismatch_nxt),
      .o_cnt (w_pop)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_ref      <= 1'b0;
         r_result   <= '0;
         r_unstable <= '0;
         r_mismatch <= '0;
         r_count    <= '0;
         r_pass     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_done  <= w_finish;
         if (w_sample && w_first)
            r_ref <= bus.dut_out;
         if (w_clear) begin
            r_result   <= '0;
            r_unstable <= '0;
         end else begin
            r_result   <= w_result_nxt;
            r_unstable <= w_unstable_nxt;
         end
         if (w_clear || bus.abort) begin
            r_mismatch <= '0;
            r_count    <= '0;
            r_pass     <= 1'b0;
         end else if (w_finish) begin
            r_mismatch <= w_mismatch_nxt;
            r_count    <= w_pop;
            r_pass     <= (w_result_nxt == EXP_TT) && (w_unstable_nxt == '0);
         end
      end
   end

   assign bus.dut_in         = r_idx;
   assign bus.busy           = (r_state == SETTLE) || (r_state == SAMPLE);
   assign bus.done           = r_done;
   assign bus.pass           = r_pass;
   assign bus.result_tt      = r_result;
   assign bus.mismatch_mask  = r_mismatch;
   assign bus.unstable_mask  = r_unstable;
   assign bus.mismatch_count = r_count;

endmodule
